// File: rtl/game_phase_sequencer_if.sv
// game_phase_sequencer_if: phase-block handshake and video bus for the phase sequencer
interface game_phase_sequencer_if #(
  parameter int NUM_PHASES = 3,
  parameter int PIX_W      = 12,
  parameter int MAX_ROUNDS = 8
);
  localparam int PH_W  = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
  localparam int RND_W = $clog2(MAX_ROUNDS + 1);
  logic [NUM_PHASES-1:0]       phase_done_in;
  logic [NUM_PHASES*PIX_W-1:0] phase_pixels_in;
  logic                        game_over_in;
  logic [PH_W-1:0]             phase_out;
  logic                        phase_start_out;
  logic [RND_W-1:0]            round_out;
  logic                        round_rst_out;
  logic                        in_over_out;
  logic [PIX_W-1:0]            pixel_out;
  modport master (
    input  phase_done_in, phase_pixels_in, game_over_in,
    output phase_out, phase_start_out, round_out, round_rst_out, in_over_out, pixel_out
  );
  modport slave (
    output phase_done_in, phase_pixels_in, game_over_in,
    input  phase_out, phase_start_out, round_out, round_rst_out, in_over_out, pixel_out
  );
endinterface

// File: rtl/game_phase_sequencer.sv
// game_phase_sequencer: advances menu/gameplay phases on done edges, counts rounds, holds game-over
module game_phase_sequencer #(
  parameter int                NUM_PHASES  = 3,
  parameter int                PIX_W       = 12,
  parameter int                MAX_ROUNDS  = 8,
  parameter int                OVER_CYCLES = 1024,
  parameter logic [PIX_W-1:0]  OVER_COLOR  = 12'hF00
) (
  input logic                   clk,
  input logic                   rst,
  game_phase_sequencer_if.master bus
);
  localparam int PH_W  = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
  localparam int RND_W = $clog2(MAX_ROUNDS + 1);
  localparam int CNT_W = (OVER_CYCLES > 2) ? $clog2(OVER_CYCLES) : 1;
  typedef enum logic [1:0] {S_RUN, S_HANDOFF, S_OVER} state_t;
  state_t                state_q;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [RND_W-1:0]      round_q, round_d;
  logic [NUM_PHASES-1:0] done_q, edg;
  logic [CNT_W-1:0]      cnt_q;
  logic [PIX_W-1:0]      pix_q;
  logic                  last, adv, lose;
  always_comb begin
    edg     = bus.phase_done_in & ~done_q;
    adv     = edg[phase_q];
    last    = phase_q == PH_W'(NUM_PHASES - 1);
    lose    = bus.game_over_in && phase_q != '0;
    phase_d = last ? PH_W'(1) : phase_q + 1'b1;
    round_d = last ? round_q + 1'b1 : round_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      phase_q <= '0;
      round_q <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      pix_q   <= '0;
    end else begin
      done_q <= bus.phase_done_in;
      pix_q  <= (state_q == S_OVER) ? OVER_COLOR : bus.phase_pixels_in[phase_q*PIX_W +: PIX_W];
      case (state_q)
        S_RUN: begin
          if (lose || (adv && round_d == RND_W'(MAX_ROUNDS))) begin
            state_q <= S_OVER;
            cnt_q   <= CNT_W'(OVER_CYCLES - 1);
            if (!lose) round_q <= round_d;
          end else if (adv) begin
            state_q <= S_HANDOFF;
            phase_q <= phase_d;
            round_q <= round_d;
          end
        end
        S_HANDOFF: state_q <= S_RUN;
        default: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= S_RUN;
            phase_q <= '0;
            round_q <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end
  assign bus.phase_out       = phase_q;
  assign bus.round_out       = round_q;
  assign bus.phase_start_out = state_q == S_HANDOFF;
  assign bus.in_over_out     = state_q == S_OVER;
  assign bus.round_rst_out   = state_q == S_OVER && cnt_q == '0;
  assign bus.pixel_out       = pix_q;
endmodule

// File: tb/tb_game_phase_sequencer.sv
// tb_game_phase_sequencer: directed stimulus with event scoreboard on two parameterisations
module tb_game_phase_sequencer;
  logic clk = 0;
  logic rst = 1;
  int   tests = 0;
  int   fails = 0;
  int   q[2][$];
  logic pov[2] = '{0, 0};
  always #5 clk = ~clk;

  game_phase_sequencer_if #(.NUM_PHASES(3), .PIX_W(12), .MAX_ROUNDS(8)) ia ();
  game_phase_sequencer_if #(.NUM_PHASES(3), .PIX_W(12), .MAX_ROUNDS(2)) ib ();

  game_phase_sequencer #(.NUM_PHASES(3), .PIX_W(12), .MAX_ROUNDS(8), .OVER_CYCLES(1024), .OVER_COLOR(12'hF00))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  game_phase_sequencer #(.NUM_PHASES(3), .PIX_W(12), .MAX_ROUNDS(2), .OVER_CYCLES(4), .OVER_COLOR(12'hF00))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Events: 100+10*phase+round = start pulse, 200 = game-over entry, 300 = round reset pulse
  task automatic sb(input int d, input int act);
    if (q[d].size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event dut%0d: got %0d expected none at %0t", d, act, $time);
    end else chk($sformatf("event_dut%0d", d), act, q[d].pop_front());
  endtask

  always @(negedge clk) begin
    if (ia.phase_start_out) sb(0, 100 + 10*int'(ia.phase_out) + int'(ia.round_out));
    if (ia.in_over_out && !pov[0]) sb(0, 200);
    if (ia.round_rst_out) sb(0, 300);
    pov[0] = ia.in_over_out;
    if (ib.phase_start_out) sb(1, 100 + 10*int'(ib.phase_out) + int'(ib.round_out));
    if (ib.in_over_out && !pov[1]) sb(1, 200);
    if (ib.round_rst_out) sb(1, 300);
    pov[1] = ib.in_over_out;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_a(input int k);
    ia.phase_done_in[k] = 1;
    cyc(1);
    ia.phase_done_in[k] = 0;
    cyc(2);
  endtask

  task automatic pulse_b(input int k);
    ib.phase_done_in[k] = 1;
    cyc(1);
    ib.phase_done_in[k] = 0;
    cyc(2);
  endtask

  task automatic chk_rst_a(input string tag);
    chk({tag, "_phase"}, int'(ia.phase_out), 0);
    chk({tag, "_round"}, int'(ia.round_out), 0);
    chk({tag, "_start"}, int'(ia.phase_start_out), 0);
    chk({tag, "_rrst"}, int'(ia.round_rst_out), 0);
    chk({tag, "_over"}, int'(ia.in_over_out), 0);
    chk({tag, "_pixel"}, int'(ia.pixel_out), 0);
  endtask

  initial begin
    ia.phase_done_in   = '0;
    ia.game_over_in    = 0;
    ia.phase_pixels_in = {12'hC00, 12'h0B0, 12'h00A};
    ib.phase_done_in   = '0;
    ib.game_over_in    = 0;
    ib.phase_pixels_in = {12'hC00, 12'h0B0, 12'h00A};
    cyc(3);
    chk_rst_a("reset");
    rst = 0;
    cyc(1);
    chk("menu_pixel", int'(ia.pixel_out), 'h00A);
    // menu handoff
    cyc(8);
    q[0].push_back(110);
    ia.phase_done_in[0] = 1;
    cyc(1);
    chk("handoff_phase", int'(ia.phase_out), 1);
    chk("handoff_start", int'(ia.phase_start_out), 1);
    cyc(1);
    chk("handoff_start_drop", int'(ia.phase_start_out), 0);
    chk("phase1_pixel", int'(ia.pixel_out), 'h0B0);
    ia.phase_done_in[0] = 0;
    // held done advances once; foreign done ignored
    q[0].push_back(120);
    ia.phase_done_in[1] = 1;
    cyc(20);
    ia.phase_done_in[1] = 0;
    chk("held_phase", int'(ia.phase_out), 2);
    chk("phase2_pixel", int'(ia.pixel_out), 'hC00);
    pulse_a(0);
    cyc(2);
    chk("foreign_phase", int'(ia.phase_out), 2);
    // round wraps skip the menu
    for (int r = 0; r < 3; r++) begin
      q[0].push_back(110 + r + 1);
      pulse_a(2);
      q[0].push_back(120 + r + 1);
      pulse_a(1);
    end
    chk("pre_wrap_round", int'(ia.round_out), 3);
    q[0].push_back(114);
    ia.phase_done_in[2] = 1;
    cyc(1);
    ia.phase_done_in[2] = 0;
    chk("wrap_phase", int'(ia.phase_out), 1);
    chk("wrap_round", int'(ia.round_out), 4);
    chk("wrap_start", int'(ia.phase_start_out), 1);
    cyc(2);
    // game-over beats a simultaneous done edge
    q[0].push_back(200);
    ia.game_over_in = 1;
    ia.phase_done_in[1] = 1;
    cyc(1);
    ia.game_over_in = 0;
    ia.phase_done_in[1] = 0;
    chk("prio_over", int'(ia.in_over_out), 1);
    chk("prio_round", int'(ia.round_out), 4);
    chk("prio_start", int'(ia.phase_start_out), 0);
    cyc(1);
    chk("over_pixel", int'(ia.pixel_out), 'hF00);
    q[0].push_back(300);
    cyc(1021);
    chk("hold_before_rrst", int'(ia.round_rst_out), 0);
    cyc(1);
    chk("hold_rrst", int'(ia.round_rst_out), 1);
    cyc(1);
    chk("exit_phase", int'(ia.phase_out), 0);
    chk("exit_round", int'(ia.round_out), 0);
    chk("exit_over", int'(ia.in_over_out), 0);
    cyc(1);
    chk("exit_pixel", int'(ia.pixel_out), 'h00A);
    // game-over ignored in menu
    ia.game_over_in = 1;
    cyc(3);
    ia.game_over_in = 0;
    chk("menu_over_ignored", int'(ia.in_over_out), 0);
    // reset mid game-over hold
    q[0].push_back(110);
    pulse_a(0);
    q[0].push_back(200);
    ia.game_over_in = 1;
    cyc(1);
    ia.game_over_in = 0;
    cyc(5);
    chk("mid_over", int'(ia.in_over_out), 1);
    rst = 1;
    cyc(1);
    chk_rst_a("rst_mid_over");
    rst = 0;
    cyc(1100);
    // max rounds forces game-over on dut_b
    rst = 1;
    cyc(2);
    rst = 0;
    cyc(2);
    q[1].push_back(110);
    pulse_b(0);
    q[1].push_back(120);
    pulse_b(1);
    q[1].push_back(111);
    pulse_b(2);
    q[1].push_back(121);
    pulse_b(1);
    q[1].push_back(200);
    ib.phase_done_in[2] = 1;
    cyc(1);
    ib.phase_done_in[2] = 0;
    chk("max_over", int'(ib.in_over_out), 1);
    chk("max_start", int'(ib.phase_start_out), 0);
    cyc(1);
    chk("max_pixel", int'(ib.pixel_out), 'hF00);
    q[1].push_back(300);
    cyc(1);
    chk("max_no_early_rrst", int'(ib.round_rst_out), 0);
    cyc(1);
    chk("max_rrst", int'(ib.round_rst_out), 1);
    cyc(1);
    chk("max_exit_phase", int'(ib.phase_out), 0);
    chk("max_exit_round", int'(ib.round_out), 0);
    chk("max_exit_over", int'(ib.in_over_out), 0);
    cyc(5);
    chk("pending_a", q[0].size(), 0);
    chk("pending_b", q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/game_phase_sequencer.md
# game_phase_sequencer

Parametrised top-level game-flow controller. It owns the current game phase (menu, then N-1 gameplay phases such as player and enemy turns) and advances on rising edges of each phase block's `done` flag. It also counts rounds, handles game-over with a timed hold, and registers the active phase's pixel onto the video path. It sits between the VGA timing generator and the per-phase renderer/logic blocks (menu, player, enemy, …).

## Interface
Parameters:
- `NUM_PHASES`, default 3: phase count. Index 0 is the menu; 1..NUM_PHASES-1 are gameplay phases, in order. Legal range is ≥2.
- `PIX_W`, default 12: pixel width (RGB444).
- `MAX_ROUNDS`, default 8: completed rounds before forced game-over. Legal range is ≥1.
- `OVER_CYCLES`, default 1024: duration of the game-over hold, in clk cycles. Legal range is ≥1.
- `OVER_COLOR`, default 12'hF00: pixel shown during game-over.
- Derived, not overridable: `PH_W = max(1, $clog2(NUM_PHASES))`, `RND_W = $clog2(MAX_ROUNDS+1)`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `phase_done_in`  in  NUM_PHASES  per-phase finished level; bit k from phase block k.
- `phase_pixels_in`  in  NUM_PHASES*PIX_W  concatenated phase pixels; phase k occupies `[k*PIX_W +: PIX_W]`.
- `game_over_in`  in  1  level; a gameplay phase reports loss.
- `phase_out`  out  PH_W  active phase index.
- `phase_start_out`  out  1  one-cycle pulse: the phase in `phase_out` begins.
- `round_out`  out  RND_W  completed-round count.
- `round_rst_out`  out  1  one-cycle pulse instructing all phase blocks to clear.
- `in_over_out`  out  1  high while in game-over hold.
- `pixel_out`  out  PIX_W  registered pixel.

## Operation
- FSM states: `S_RUN`, `S_HANDOFF`, `S_OVER`.
- Edge detect: `done_q <= phase_done_in` every cycle, in every state. `edge[k] = phase_done_in[k] & ~done_q[k]`.
- `S_RUN`:
  - Only `edge[phase_out]` is honoured. Edges on other bits are ignored and are not remembered.
  - On an honoured edge, compute `next = phase_out+1`.
  - If `phase_out == NUM_PHASES-1`, then `next = 1` and `round_out` increments. If the incremented value equals MAX_ROUNDS, go to `S_OVER` instead of handing off.
  - Otherwise load `phase_out <= next` and go to `S_HANDOFF`.
- `game_over_in` high in `S_RUN` with `phase_out != 0` goes to `S_OVER`. It takes priority over a simultaneous done edge; `round_out` does not increment in that case.
- `game_over_in` is ignored while `phase_out == 0`, and in `S_HANDOFF` and `S_OVER`.
- `S_HANDOFF`: lasts exactly 1 cycle. `phase_start_out = 1`. Done edges arriving this cycle are ignored. Then go to `S_RUN`.
- `S_OVER`:
  - On entry, load the hold counter with OVER_CYCLES-1. It decrements each cycle.
  - On the cycle the counter is 0: pulse `round_rst_out`, set `phase_out <= 0`, `round_out <= 0`, clear `done_q`, and go to `S_RUN`.
  - `in_over_out = (state == S_OVER)`.
- The menu (phase 0) receives no start pulse. It is active whenever `phase_out == 0`.
- Pixel path: `pixel_out <= (state == S_OVER) ? OVER_COLOR : phase_pixels_in[phase_out*PIX_W +: PIX_W]`.
- `round_out` saturates by construction: it never exceeds MAX_ROUNDS-1 outside `S_OVER`.

## Timing
- Reset values: `S_RUN`, `phase_out = 0`, `round_out = 0`, `phase_start_out = 0`, `round_rst_out = 0`, `in_over_out = 0`, `pixel_out = 0`, `done_q = 0`, hold counter = 0.
- Done edge sampled at cycle t:
  - t+1: `phase_out = next`, `phase_start_out = 1`.
  - t+2: `S_RUN` on the new phase; the earliest next honoured edge can be sampled.
- A done level held high produces exactly one advance. The phase block must drop `done` and raise it again to advance a second time.
- Game-over, or max-round edge, at cycle t:
  - `in_over_out` rises at t+1.
  - `round_rst_out` pulses at cycle t+OVER_CYCLES.
  - `phase_out = 0` from t+OVER_CYCLES+1.
- Pixel latency is 1 cycle from `phase_pixels_in`/`phase_out`. `pixel_out` switches to the new phase's source one cycle after `phase_out` changes.
- `phase_start_out`, `round_rst_out` and `in_over_out` are decoded from registered state and have no combinational input paths.
- `rst` asserted in any state, including mid-`S_OVER` or mid-`S_HANDOFF`, restores the reset values on the next edge. `round_rst_out` is not pulsed by `rst`.

## Test plan
Defaults unless stated: NUM_PHASES=3, MAX_ROUNDS=8, OVER_CYCLES=1024.
- **Menu handoff:** release rst, raise `phase_done_in[0]` at cycle 10 → cycle 11 `phase_out = 1`, `phase_start_out = 1` for one cycle; cycle 12 `phase_start_out = 0`.
- **Held and foreign done:** hold `phase_done_in[1]` high for 20 cycles → exactly one advance to phase 2. Pulse `phase_done_in[0]` while in phase 2 → no change.
- **Round wrap:** phase 2 done edge with `round_out = 3` → `phase_out = 1`, `round_out = 4`, start pulse; menu is skipped.
- **Max rounds:** MAX_ROUNDS=2, OVER_CYCLES=4, complete 2 rounds. At the last phase 2 edge (cycle t) → `in_over_out = 1` at t+1, `pixel_out = 12'hF00` at t+2, `round_rst_out` pulse at t+4, then `phase_out = 0`, `round_out = 0`.
- **Priority:** `game_over_in` and `phase_done_in[1]` edge in the same cycle while in phase 1 → `S_OVER`, `round_out` unchanged, no start pulse. `game_over_in` during phase 0 → ignored.
- **Pixel mux and reset:** drive distinct constants 12'h00A/12'h0B0/12'hC00 on phases 0/1/2 → `pixel_out` tracks the active phase with 1-cycle lag. Assert rst mid-`S_OVER` → all outputs return to reset values next cycle, with no `round_rst_out` pulse.
